uart_rx_cmd_ctrl: RTL and testbench

Command sequencer behind the UART receiver. It consumes received bytes and their error flags, and parses framed commands: register write, register read, and receiver reconfiguration. It drives the register-file port, holds read-back data for the transmit path, and owns the live prescale/parity configuration fed back to the receiver. Every state that waits for a byte is guarded by an inter-byte timeout.

---
 rtl/uart_rx_cmd_ctrl.sv | 262 ++++++++++++++++++++++++++
 tb/tb_uart_rx_cmd_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cmd_ctrl.sv
// uart_rx_cmd_ctrl
// Sits behind the UART receiver. It parses framed commands out of the received
// byte stream:
//   0xAA addr data -> register write (one-cycle wr_en)
//   0xBB addr      -> register read (one-cycle rd_en), then the read-back byte
//                     is held on tx_data/tx_valid until the transmitter takes it
//   0xCC cfg       -> new receiver configuration {par_typ, par_en, prescale[5:0]}
// Any errored byte, unknown command, zero prescale, stray byte during a read, or
// inter-byte timeout aborts the frame: one-cycle frame_err pulse and a saturating
// err_cnt increment.
//
// Ports:
//   clk_RX, rst                    clock and synchronous active-high reset
//   rx_data/rx_valid/rx_par_err/rx_stp_err  received byte and its error flags
//   wr_en/rd_en/addr/wr_data       register-file command port
//   rd_data/rd_valid               register-file read return
//   tx_data/tx_valid/tx_ready      read-back byte towards the transmitter
//   cfg_prescale/cfg_par_en/cfg_par_typ  live receiver configuration
//   frame_err/err_cnt              abort pulse and saturating abort counter
module uart_rx_cmd_ctrl #(
  parameter int DATAWIDTH      = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int DEF_PRESCALE   = 32,
  parameter int DEF_PAR_EN     = 1,
  parameter int DEF_PAR_TYP    = 0
) (
  input  logic                  clk_RX,
  input  logic                  rst,
  input  logic [DATAWIDTH-1:0]  rx_data,
  input  logic                  rx_valid,
  input  logic                  rx_par_err,
  input  logic                  rx_stp_err,
  output logic                  wr_en,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATAWIDTH-1:0]  wr_data,
  input  logic [DATAWIDTH-1:0]  rd_data,
  input  logic                  rd_valid,
  output logic [DATAWIDTH-1:0]  tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [5:0]            cfg_prescale,
  output logic                  cfg_par_en,
  output logic                  cfg_par_typ,
  output logic                  frame_err,
  output logic [7:0]            err_cnt
);

  localparam logic [DATAWIDTH-1:0] CMD_WR  = DATAWIDTH'(8'hAA);
  localparam logic [DATAWIDTH-1:0] CMD_RD  = DATAWIDTH'(8'hBB);
  localparam logic [DATAWIDTH-1:0] CMD_CFG = DATAWIDTH'(8'hCC);

  localparam int                TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMO_W-1:0]  TMO_ONE  = TMO_W'(1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_ADDR  = 3'd1,
    WR_DATA  = 3'd2,
    RD_ADDR  = 3'd3,
    RD_WAIT  = 3'd4,
    TX_HOLD  = 3'd5,
    CFG_DATA = 3'd6
  } state_t;

  // States in which an inter-byte (or read-return) timeout applies.
  function automatic logic tmo_active(input state_t s);
    case (s)
      WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, CFG_DATA: return 1'b1;
      default:                                      return 1'b0;
    endcase
  endfunction

  // Error counter increment that sticks at its maximum.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t           state_r;
  state_t           next_state_s;
  logic [TMO_W-1:0] tmo_cnt_r;
  logic             good_s;
  logic             bad_s;
  logic             tmo_hit_s;
  logic             abort_s;
  logic             ld_addr_s;
  logic             ld_wdata_s;
  logic             rd_pulse_s;
  logic             ld_tx_s;
  logic             tx_done_s;
  logic             ld_cfg_s;

  assign good_s    = rx_valid & ~rx_par_err & ~rx_stp_err;
  assign bad_s     = rx_valid & (rx_par_err | rx_stp_err);
  assign tmo_hit_s = tmo_active(state_r) && (tmo_cnt_r == TMO_LAST);

  // Next-state and per-cycle action decode. Errors are checked first, then a
  // good byte, then the timeout, so a byte arriving on the expiry cycle wins.
  always_comb begin
    next_state_s = state_r;
    abort_s      = 1'b0;
    ld_addr_s    = 1'b0;
    ld_wdata_s   = 1'b0;
    rd_pulse_s   = 1'b0;
    ld_tx_s      = 1'b0;
    tx_done_s    = 1'b0;
    ld_cfg_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (bad_s) begin
          abort_s = 1'b1;
        end else if (good_s) begin
          case (rx_data)
            CMD_WR:  next_state_s = WR_ADDR;
            CMD_RD:  next_state_s = RD_ADDR;
            CMD_CFG: next_state_s = CFG_DATA;
            default: abort_s      = 1'b1;
          endcase
        end else begin
          next_state_s = IDLE;
        end
      end
      WR_ADDR, WR_DATA, RD_ADDR, CFG_DATA: begin
        if (bad_s || (!good_s && tmo_hit_s)) begin
          abort_s      = 1'b1;
          next_state_s = IDLE;
        end else if (good_s) begin
          case (state_r)
            WR_ADDR: begin
              ld_addr_s    = 1'b1;
              next_state_s = WR_DATA;
            end
            WR_DATA: begin
              ld_wdata_s   = 1'b1;
              next_state_s = IDLE;
            end
            RD_ADDR: begin
              ld_addr_s    = 1'b1;
              rd_pulse_s   = 1'b1;
              next_state_s = RD_WAIT;
            end
            default: begin
              // A zero prescale would stall the receiver, so it is refused.
              next_state_s = IDLE;
              if (rx_data[5:0] == 6'd0) begin
                abort_s = 1'b1;
              end else begin
                ld_cfg_s = 1'b1;
              end
            end
          endcase
        end else begin
          next_state_s = state_r;
        end
      end
      RD_WAIT: begin
        // Any byte during a pending read is dropped and kills the frame.
        if (rx_valid || (!rd_valid && tmo_hit_s)) begin
          abort_s      = 1'b1;
          next_state_s = IDLE;
        end else if (rd_valid) begin
          ld_tx_s      = 1'b1;
          next_state_s = TX_HOLD;
        end else begin
          next_state_s = RD_WAIT;
        end
      end
      TX_HOLD: begin
        if (rx_valid) begin
          abort_s      = 1'b1;
          next_state_s = IDLE;
        end else if (tx_ready) begin
          tx_done_s    = 1'b1;
          next_state_s = IDLE;
        end else begin
          next_state_s = TX_HOLD;
        end
      end
      default: begin
        abort_s      = 1'b0;
        next_state_s = IDLE;
      end
    endcase
  end

  // State register and timeout counter; the counter restarts on every state
  // change and every good byte, and idles at zero outside guarded states.
  always_ff @(posedge clk_RX) begin
    if (rst) begin
      state_r   <= IDLE;
      tmo_cnt_r <= '0;
    end else begin
      state_r <= next_state_s;
      if ((next_state_s != state_r) || good_s || !tmo_active(state_r)) begin
        tmo_cnt_r <= '0;
      end else begin
        tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
      end
    end
  end

  // Register-file command port: strobes fire the cycle after the deciding byte.
  always_ff @(posedge clk_RX) begin
    if (rst) begin
      wr_en   <= 1'b0;
      rd_en   <= 1'b0;
      addr    <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= ld_wdata_s;
      rd_en <= rd_pulse_s;
      if (ld_addr_s) begin
        addr <= rx_data[ADDR_WIDTH-1:0];
      end
      if (ld_wdata_s) begin
        wr_data <= rx_data;
      end
    end
  end

  // Read-back holding register towards the transmitter.
  always_ff @(posedge clk_RX) begin
    if (rst) begin
      tx_data  <= '0;
      tx_valid <= 1'b0;
    end else if (ld_tx_s) begin
      tx_data  <= rd_data;
      tx_valid <= 1'b1;
    end else if (abort_s || tx_done_s) begin
      tx_valid <= 1'b0;
    end
  end

  // Live receiver configuration.
  always_ff @(posedge clk_RX) begin
    if (rst) begin
      cfg_prescale <= 6'(DEF_PRESCALE);
      cfg_par_en   <= 1'(DEF_PAR_EN);
      cfg_par_typ  <= 1'(DEF_PAR_TYP);
    end else if (ld_cfg_s) begin
      cfg_prescale <= rx_data[5:0];
      cfg_par_en   <= rx_data[6];
      cfg_par_typ  <= rx_data[7];
    end
  end

  // Abort reporting: one-cycle pulse plus saturating count.
  always_ff @(posedge clk_RX) begin
    if (rst) begin
      frame_err <= 1'b0;
      err_cnt   <= 8'd0;
    end else begin
      frame_err <= abort_s;
      if (abort_s) begin
        err_cnt <= sat_inc8(err_cnt);
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cmd_ctrl.sv
// Self-checking bench for uart_rx_cmd_ctrl: directed frames followed by random
// frames, compared against a frame-level reference model (expected writes,
// expected read strobes, expected aborts, expected configuration).
`timescale 1ns/1ps
module tb_uart_rx_cmd_ctrl;

  localparam int TMO = 4096;

  logic       clk_RX = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_par_err;
  logic       rx_stp_err;
  logic       wr_en;
  logic       rd_en;
  logic [3:0] addr;
  logic [7:0] wr_data;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [5:0] cfg_prescale;
  logic       cfg_par_en;
  logic       cfg_par_typ;
  logic       frame_err;
  logic [7:0] err_cnt;

  uart_rx_cmd_ctrl #(
    .DATAWIDTH(8), .ADDR_WIDTH(4), .TIMEOUT_CYCLES(TMO),
    .DEF_PRESCALE(32), .DEF_PAR_EN(1), .DEF_PAR_TYP(0)
  ) dut (
    .clk_RX(clk_RX), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_par_err(rx_par_err), .rx_stp_err(rx_stp_err),
    .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .wr_data(wr_data),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .cfg_prescale(cfg_prescale), .cfg_par_en(cfg_par_en), .cfg_par_typ(cfg_par_typ),
    .frame_err(frame_err), .err_cnt(err_cnt)
  );

  always #5 clk_RX = ~clk_RX;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state (frame level).
  int          m_err;
  int          m_fe;
  int          m_rd;
  logic [5:0]  m_pre;
  logic        m_pen;
  logic        m_ptyp;
  logic [11:0] exp_wr_q[$];

  // Observed events, collected mid-cycle.
  logic [11:0] obs_wr_q[$];
  int          fe_seen = 0;
  int          rd_seen = 0;

  always @(negedge clk_RX) begin
    if (wr_en)     obs_wr_q.push_back({addr, wr_data});
    if (rd_en)     rd_seen = rd_seen + 1;
    if (frame_err) fe_seen = fe_seen + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_RX);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic pe, input logic se);
    rx_data    = b;
    rx_valid   = 1'b1;
    rx_par_err = pe;
    rx_stp_err = se;
    step();
    rx_valid   = 1'b0;
    rx_par_err = 1'b0;
    rx_stp_err = 1'b0;
    rx_data    = 8'($urandom);
  endtask

  task automatic model_abort();
    m_err++;
    m_fe++;
  endtask

  // Compare everything the model tracks; drains the write scoreboard.
  task automatic check_state(input string tag);
    logic [11:0] o;
    logic [11:0] e;
    check({tag, "_prescale"}, 32'(cfg_prescale), 32'(m_pre));
    check({tag, "_par_en"},   32'(cfg_par_en),   32'(m_pen));
    check({tag, "_par_typ"},  32'(cfg_par_typ),  32'(m_ptyp));
    check({tag, "_err_cnt"},  32'(err_cnt),      (m_err > 255) ? 32'd255 : 32'(m_err));
    check({tag, "_fe_count"}, 32'(fe_seen),      32'(m_fe));
    check({tag, "_rd_count"}, 32'(rd_seen),      32'(m_rd));
    check({tag, "_tx_valid"}, 32'(tx_valid),     32'd0);
    check({tag, "_wr_count"}, 32'(obs_wr_q.size()), 32'(exp_wr_q.size()));
    while (obs_wr_q.size() > 0 && exp_wr_q.size() > 0) begin
      o = obs_wr_q.pop_front();
      e = exp_wr_q.pop_front();
      check({tag, "_wr_addr_data"}, 32'(o), 32'(e));
    end
    obs_wr_q.delete();
    exp_wr_q.delete();
  endtask

  task automatic wr_frame(input logic [7:0] a, input logic [7:0] d);
    send(8'hAA, 1'b0, 1'b0);
    send(a, 1'b0, 1'b0);
    send(d, 1'b0, 1'b0);
    check("wr_en_pulse", 32'(wr_en), 32'd1);
    check("wr_addr", 32'(addr), 32'(a[3:0]));
    check("wr_data", 32'(wr_data), 32'(d));
    exp_wr_q.push_back({a[3:0], d});
    step();
    check("wr_en_drop", 32'(wr_en), 32'd0);
  endtask

  // Return read data after lat cycles, hold off the transmitter for hold cycles.
  task automatic rd_finish(input logic [7:0] d, input int lat, input int hold);
    repeat (lat) step();
    rd_data  = d;
    rd_valid = 1'b1;
    step();
    rd_valid = 1'b0;
    rd_data  = 8'($urandom);
    check("tx_valid_set", 32'(tx_valid), 32'd1);
    check("tx_data", 32'(tx_data), 32'(d));
    for (int k = 0; k < hold; k++) begin
      step();
      check("tx_valid_hold", 32'(tx_valid), 32'd1);
      check("tx_data_hold", 32'(tx_data), 32'(d));
    end
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    check("tx_valid_clr", 32'(tx_valid), 32'd0);
  endtask

  task automatic rd_frame(input logic [7:0] a, input logic [7:0] d, input int lat, input int hold);
    send(8'hBB, 1'b0, 1'b0);
    send(a, 1'b0, 1'b0);
    check("rd_en_pulse", 32'(rd_en), 32'd1);
    check("rd_addr", 32'(addr), 32'(a[3:0]));
    m_rd++;
    rd_finish(d, lat, hold);
  endtask

  task automatic cfg_frame(input logic [7:0] b);
    send(8'hCC, 1'b0, 1'b0);
    send(b, 1'b0, 1'b0);
    if (b[5:0] == 6'd0) begin
      model_abort();
      check("cfg_reject_fe", 32'(frame_err), 32'd1);
    end else begin
      m_pre  = b[5:0];
      m_pen  = b[6];
      m_ptyp = b[7];
      check("cfg_accept_fe", 32'(frame_err), 32'd0);
    end
  endtask

  logic [7:0] b;
  logic [7:0] a;
  logic [7:0] d;
  logic       pe;
  logic       se;
  int         kind;
  int         sel;

  initial begin
    rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; rx_par_err = 1'b0; rx_stp_err = 1'b0;
    rd_data = 8'h00; rd_valid = 1'b0; tx_ready = 1'b0;
    m_err = 0; m_fe = 0; m_rd = 0; m_pre = 6'd32; m_pen = 1'b1; m_ptyp = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_rd_en", 32'(rd_en), 32'd0);
    check("rst_addr", 32'(addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check_state("reset");

    // Plan write frame.
    wr_frame(8'h35, 8'h5C);
    check_state("write");

    // Plan read frame: rd_valid two cycles after rd_en, transmitter stalls 10 cycles.
    rd_frame(8'h03, 8'hA7, 2, 10);
    check_state("read");

    // Plan config frames.
    cfg_frame(8'hD0);
    check("cfg_d0_prescale", 32'(cfg_prescale), 32'd16);
    check("cfg_d0_par", 32'({cfg_par_typ, cfg_par_en}), 32'd3);
    cfg_frame(8'h00);
    check("cfg_zero_err_cnt", 32'(err_cnt), 32'd1);
    step();
    check_state("config");

    // Parity error inside a write frame, then an unknown command.
    send(8'hAA, 1'b0, 1'b0);
    send(8'h42, 1'b1, 1'b0);
    check("par_err_fe", 32'(frame_err), 32'd1);
    check("par_err_no_wr", 32'(wr_en), 32'd0);
    model_abort();
    send(8'h11, 1'b0, 1'b0);
    check("unknown_cmd_fe", 32'(frame_err), 32'd1);
    model_abort();
    step();
    check_state("errors");

    // Timeout: exactly TMO silent cycles after the read command aborts.
    send(8'hBB, 1'b0, 1'b0);
    repeat (TMO - 1) step();
    check("tmo_early_fe", 32'(frame_err), 32'd0);
    step();
    check("tmo_fe", 32'(frame_err), 32'd1);
    check("tmo_no_rd", 32'(rd_en), 32'd0);
    model_abort();
    step();
    check_state("timeout");

    // Good byte on the expiry cycle wins.
    send(8'hBB, 1'b0, 1'b0);
    repeat (TMO - 1) step();
    send(8'h07, 1'b0, 1'b0);
    check("tmo_race_rd_en", 32'(rd_en), 32'd1);
    check("tmo_race_fe", 32'(frame_err), 32'd0);
    check("tmo_race_addr", 32'(addr), 32'd7);
    m_rd++;
    rd_finish(8'h3C, 1, 0);
    step();
    check_state("timeout_race");

    // Stray byte while the read-back is held drops tx_valid and aborts.
    send(8'hBB, 1'b0, 1'b0);
    send(8'h02, 1'b0, 1'b0);
    m_rd++;
    rd_valid = 1'b1; rd_data = 8'h99;
    step();
    rd_valid = 1'b0;
    check("hold_tx_valid", 32'(tx_valid), 32'd1);
    send(8'h55, 1'b0, 1'b0);
    check("hold_abort_fe", 32'(frame_err), 32'd1);
    check("hold_abort_tx_valid", 32'(tx_valid), 32'd0);
    model_abort();
    step();
    check_state("hold_abort");

    // Random frames.
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) begin
        rd_valid = 1'($urandom_range(0, 1));
        rd_data  = 8'($urandom);
        step();
      end
      rd_valid = 1'b0;
      kind = $urandom_range(0, 4);
      case (kind)
        0: wr_frame(8'($urandom), 8'($urandom));
        1: rd_frame(8'($urandom), 8'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
        2: begin
          b = 8'($urandom);
          if ($urandom_range(0, 3) == 0) b[5:0] = 6'd0;
          cfg_frame(b);
        end
        3: begin
          do b = 8'($urandom); while (b == 8'hAA || b == 8'hBB || b == 8'hCC);
          send(b, 1'b0, 1'b0);
          check("rand_unknown_fe", 32'(frame_err), 32'd1);
          model_abort();
        end
        default: begin
          sel = $urandom_range(0, 3);
          if (sel == 0) send(8'hAA, 1'b0, 1'b0);
          if (sel == 1) send(8'hBB, 1'b0, 1'b0);
          if (sel == 2) send(8'hCC, 1'b0, 1'b0);
          if (sel == 0 && $urandom_range(0, 1) == 1) send(8'($urandom), 1'b0, 1'b0);
          pe = 1'($urandom_range(0, 1));
          se = pe ? 1'($urandom_range(0, 1)) : 1'b1;
          send(8'($urandom), pe, se);
          check("rand_bad_fe", 32'(frame_err), 32'd1);
          check("rand_bad_no_wr", 32'(wr_en), 32'd0);
          model_abort();
        end
      endcase
      step();
      check_state("random");
    end

    // Drive err_cnt past its ceiling.
    repeat (260) begin
      send(8'h11, 1'b0, 1'b0);
      model_abort();
    end
    step();
    check("sat_err_cnt", 32'(err_cnt), 32'd255);
    check_state("saturate");

    // Reset in WR_DATA with the data byte arriving on the reset edge.
    send(8'hAA, 1'b0, 1'b0);
    send(8'h05, 1'b0, 1'b0);
    rst = 1'b1; rx_data = 8'h5C; rx_valid = 1'b1;
    step();
    rst = 1'b0; rx_valid = 1'b0;
    check("rst_mid_wr_en", 32'(wr_en), 32'd0);
    check("rst_mid_err_cnt", 32'(err_cnt), 32'd0);
    check("rst_mid_cfg", 32'({cfg_par_typ, cfg_par_en, cfg_prescale}), 32'h60);
    check("rst_mid_addr", 32'(addr), 32'd0);
    check("rst_mid_fe", 32'(frame_err), 32'd0);
    m_err = 0; m_pre = 6'd32; m_pen = 1'b1; m_ptyp = 1'b0;
    // Back in IDLE, so a lone data byte is an unknown command.
    send(8'h5C, 1'b0, 1'b0);
    check("rst_idle_fe", 32'(frame_err), 32'd1);
    check("rst_idle_no_wr", 32'(wr_en), 32'd0);
    model_abort();
    step();
    check_state("reset_mid");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
